// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file family.
package rf_pkg;

   localparam int RF_XLEN_DEF  = 32;
   localparam int RF_NREGS_DEF = 32;

   function automatic int rf_aw(input int nregs);
      return $clog2(nregs);
   endfunction

endpackage

// File: rtl/rf_mp_sb_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, set wins on collision.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int  NREGS = RF_NREGS_DEF,
   parameter int  NWR   = 2,
   localparam int AW    = rf_aw(NREGS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_set_en,
   input  logic [AW-1:0]     i_set_addr,
   input  logic [NWR-1:0]    i_clr_en,
   input  logic [NWR*AW-1:0] i_clr_addr,
   output logic [NREGS-1:0]  o_busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NWR; w++) begin
         if (i_clr_en[w]) begin
            busy_d[i_clr_addr[w*AW +: AW]] = 1'b0;
         end
      end
      if (i_set_en) begin
         busy_d[i_set_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign o_busy = busy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file with x0 hardwired to zero and optional forwarding.
// Busy-bit scoreboard is built only when RF_SCOREBOARD_EN is defined.
module rf_mp_sb
   import rf_pkg::*;
#(
   parameter int  XLEN      = RF_XLEN_DEF,
   parameter int  NREGS     = RF_NREGS_DEF,
   parameter int  NRD       = 2,
   parameter int  NWR       = 2,
   parameter int  BYPASS_EN = 0,
   localparam int AW        = rf_aw(NREGS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NRD*AW-1:0]   i_raddr,
   output logic [NRD*XLEN-1:0] o_rdata,
   output logic [NRD-1:0]      o_rbusy,
   input  logic [NWR-1:0]      i_wen,
   input  logic [NWR*AW-1:0]   i_waddr,
   input  logic [NWR*XLEN-1:0] i_wdata,
   input  logic                i_iss_en,
   input  logic [AW-1:0]       i_iss_rd,
   output logic                o_iss_stall,
   output logic                o_wr_conflict
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [AW-1:0]   waddr [NWR];
   logic [XLEN-1:0] wdata [NWR];
   logic [NWR-1:0]  wvalid;
   logic [AW-1:0]   raddr [NRD];
   logic [NRD-1:0]  fwd_hit;
   logic            wr_conflict_d;
   logic            wr_conflict_q;

   genvar gi;

   // A write only counts when enabled and aimed at a real register.
   generate
      for (gi = 0; gi < NWR; gi++) begin : g_wr
         assign waddr[gi]  = i_waddr[gi*AW +: AW];
         assign wdata[gi]  = i_wdata[gi*XLEN +: XLEN];
         assign wvalid[gi] = i_wen[gi] && (waddr[gi] != '0);
      end
   endgenerate

   // Higher-numbered ports are applied last, so port 1 wins a same-address write.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wvalid[w]) begin
               regs_q[waddr[w]] <= wdata[w];
            end
         end
      end
   end

   generate
      if (NWR > 1) begin : g_conf
         assign wr_conflict_d = wvalid[0] && wvalid[1] && (waddr[0] == waddr[1]);
      end else begin : g_noconf
         assign wr_conflict_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_conflict_q <= 1'b0;
      end else begin
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign o_wr_conflict = wr_conflict_q;

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic            hit;
         logic [XLEN-1:0] fwd_data;

         assign raddr[gi] = i_raddr[gi*AW +: AW];

         always_comb begin
            hit      = 1'b0;
            fwd_data = '0;
            for (int w = 0; w < NWR; w++) begin
               if (wvalid[w] && (waddr[w] == raddr[gi])) begin
                  hit      = 1'b1;
                  fwd_data = wdata[w];
               end
            end
         end

         assign fwd_hit[gi] = (BYPASS_EN != 0) && hit;
         assign o_rdata[gi*XLEN +: XLEN] = fwd_hit[gi] ? fwd_data :
                                           (raddr[gi] == '0) ? {XLEN{1'b0}} : regs_q[raddr[gi]];
      end
   endgenerate

`ifdef RF_SCOREBOARD_EN
   logic [NREGS-1:0] busy;
   logic [NWR-1:0]   wr_to_iss;
   logic             iss_stall;
   logic             iss_set;

   rf_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR)
   ) u_scoreboard (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_set_en   (iss_set),
      .i_set_addr (i_iss_rd),
      .i_clr_en   (wvalid),
      .i_clr_addr (i_waddr),
      .o_busy     (busy)
   );

   generate
      for (gi = 0; gi < NWR; gi++) begin : g_iss_hit
         assign wr_to_iss[gi] = wvalid[gi] && (waddr[gi] == i_iss_rd);
      end
      for (gi = 0; gi < NRD; gi++) begin : g_rbusy
         assign o_rbusy[gi] = busy[raddr[gi]] && !fwd_hit[gi];
      end
   endgenerate

   // With forwarding, a result landing this cycle resolves the WAW hazard.
   assign iss_stall   = i_iss_en && busy[i_iss_rd] && !((BYPASS_EN != 0) && (|wr_to_iss));
   assign iss_set     = i_iss_en && (i_iss_rd != '0) && !iss_stall;
   assign o_iss_stall = iss_stall;
`else
   logic unused_iss;
   assign unused_iss  = ^{i_iss_en, i_iss_rd};
   assign o_rbusy     = '0;
   assign o_iss_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_mp_sb.sv
// Scoreboard bench: one DUT without and one with forwarding, shared stimulus.
module tb_rf_mp_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
`ifdef RF_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   localparam int K_RDATA = 0;
   localparam int K_RBUSY = 1;
   localparam int K_STALL = 2;
   localparam int K_CONF  = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   raddr;
   logic [NWR-1:0]      wen;
   logic [NWR*AW-1:0]   waddr;
   logic [NWR*XLEN-1:0] wdata;
   logic                iss_en;
   logic [AW-1:0]       iss_rd;
   logic [NRD*XLEN-1:0] rdata0, rdata1;
   logic [NRD-1:0]      rbusy0, rbusy1;
   logic                stall0, stall1, conf0, conf1;

   always #5 clk = ~clk;

   rf_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS_EN(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata0), .o_rbusy(rbusy0),
      .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_iss_en(iss_en), .i_iss_rd(iss_rd),
      .o_iss_stall(stall0), .o_wr_conflict(conf0)
   );

   rf_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS_EN(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata1), .o_rbusy(rbusy1),
      .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_iss_en(iss_en), .i_iss_rd(iss_rd),
      .o_iss_stall(stall1), .o_wr_conflict(conf1)
   );

   typedef struct {
      string       tag;
      int          kind;
      int          d;
      int          p;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem_m [NREGS];
   bit          busy_m [2][NREGS];
   bit          conf_m;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] ra(input int k);
      return raddr[k*AW +: AW];
   endfunction

   function automatic logic [AW-1:0] wa(input int w);
      return waddr[w*AW +: AW];
   endfunction

   function automatic logic [31:0] wd(input int w);
      return wdata[w*XLEN +: XLEN];
   endfunction

   function automatic bit wr_hits(input logic [AW-1:0] a);
      bit h;
      h = 1'b0;
      for (int w = 0; w < NWR; w++) if (wen[w] && wa(w) == a && a != 0) h = 1'b1;
      return h;
   endfunction

   function automatic logic [31:0] exp_rdata(input int d, input int k);
      logic [AW-1:0] a;
      logic [31:0]   v;
      a = ra(k);
      v = (a == 0) ? 32'h0 : mem_m[a];
      if (d == 1) begin
         for (int w = 0; w < NWR; w++) if (wen[w] && wa(w) == a && a != 0) v = wd(w);
      end
      return v;
   endfunction

   function automatic bit exp_rbusy(input int d, input int k);
      return SB_EN && busy_m[d][ra(k)] && !(d == 1 && wr_hits(ra(k)));
   endfunction

   function automatic bit exp_stall(input int d);
      return SB_EN && iss_en && busy_m[d][iss_rd] && !(d == 1 && wr_hits(iss_rd));
   endfunction

   function automatic logic [31:0] get_act(input int kind, input int d, input int p);
      case (kind)
         K_RDATA: return (d == 1) ? rdata1[p*XLEN +: XLEN] : rdata0[p*XLEN +: XLEN];
         K_RBUSY: return {31'b0, (d == 1) ? rbusy1[p] : rbusy0[p]};
         K_STALL: return {31'b0, (d == 1) ? stall1 : stall0};
         default: return {31'b0, (d == 1) ? conf1 : conf0};
      endcase
   endfunction

   task automatic push_exp(input string tag, input int kind, input int d, input int p, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.d = d; e.p = p; e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic push_auto();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < NRD; k++) begin
            push_exp($sformatf("rdata_d%0d_p%0d", d, k), K_RDATA, d, k, exp_rdata(d, k));
            push_exp($sformatf("rbusy_d%0d_p%0d", d, k), K_RBUSY, d, k, {31'b0, exp_rbusy(d, k)});
         end
         push_exp($sformatf("stall_d%0d", d), K_STALL, d, 0, {31'b0, exp_stall(d)});
         push_exp($sformatf("conflict_d%0d", d), K_CONF, d, 0, {31'b0, conf_m});
      end
   endtask

   task automatic flush();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, get_act(e.kind, e.d, e.p), e.val);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < NREGS; r++) begin
         mem_m[r] = 32'h0;
         busy_m[0][r] = 1'b0;
         busy_m[1][r] = 1'b0;
      end
      conf_m = 1'b0;
   endtask

   task automatic drive(input logic [1:0] we, input int wa0, input logic [31:0] wd0,
                        input int wa1, input logic [31:0] wd1, input int r0, input int r1,
                        input logic ie, input int ird);
      wen    = we;
      waddr  = {AW'(wa1), AW'(wa0)};
      wdata  = {wd1, wd0};
      raddr  = {AW'(r1), AW'(r0)};
      iss_en = ie;
      iss_rd = AW'(ird);
   endtask

   // Check the comb view at the falling edge, then advance the model past the rising edge.
   task automatic cycle();
      logic [31:0] mem_n [NREGS];
      bit          busy_n [2][NREGS];
      bit          conf_n;
      bit          setv;
      push_auto();
      @(negedge clk);
      flush();
      mem_n  = mem_m;
      busy_n = busy_m;
      conf_n = 1'b0;
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mem_n[r] = 32'h0; busy_n[0][r] = 1'b0; busy_n[1][r] = 1'b0;
         end
      end else begin
         for (int w = 0; w < NWR; w++) if (wen[w] && wa(w) != 0) mem_n[wa(w)] = wd(w);
         conf_n = (wen == 2'b11) && (wa(0) == wa(1)) && (wa(0) != 0);
         for (int d = 0; d < 2; d++) begin
            setv = iss_en && (iss_rd != 0) && !exp_stall(d);
            for (int w = 0; w < NWR; w++) if (wen[w] && wa(w) != 0) busy_n[d][wa(w)] = 1'b0;
            if (setv) busy_n[d][iss_rd] = 1'b1;
         end
      end
      $display("cyc %0d rst=%0b wen=%b waddr=%h wdata=%h raddr=%h iss=%0b/%0d rdata0=%h rdata1=%h rbusy=%b/%b stall=%0b/%0b conf=%0b",
               cyc, rst, wen, waddr, wdata, raddr, iss_en, iss_rd, rdata0, rdata1, rbusy0, rbusy1, stall0, stall1, conf0);
      @(posedge clk);
      #1;
      mem_m  = mem_n;
      busy_m = busy_n;
      conf_m = conf_n;
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      model_clear();
      drive(2'b00, 0, 0, 0, 0, 5, 7, 1'b0, 0);
      #1;
      push_exp("reset_conflict", K_CONF, 0, 0, 32'h0);
      flush();
      cycle();
      cycle();
      rst = 1'b0;

      // basic write / read, x0 immutable
      drive(2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1'b0, 0);
      push_exp("x5_old", K_RDATA, 0, 0, 32'h0);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 5, 0, 1'b0, 0);
      push_exp("x5_read", K_RDATA, 0, 0, 32'hDEADBEEF);
      push_exp("x5_read_byp", K_RDATA, 1, 0, 32'hDEADBEEF);
      cycle();
      drive(2'b01, 0, 32'h1234, 0, 0, 0, 0, 1'b0, 0);
      push_exp("x0_no_fwd", K_RDATA, 1, 0, 32'h0);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 0, 5, 1'b0, 0);
      push_exp("x0_read", K_RDATA, 0, 0, 32'h0);
      cycle();

      // dual write to x7
      drive(2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 1'b0, 0);
      push_exp("conf_before", K_CONF, 0, 0, 32'h0);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 7, 0, 1'b0, 0);
      push_exp("x7_port1_wins", K_RDATA, 0, 0, 32'h22);
      push_exp("conf_pulse", K_CONF, 0, 0, 32'h1);
      push_exp("conf_pulse_byp", K_CONF, 1, 0, 32'h1);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 7, 0, 1'b0, 0);
      push_exp("conf_one_cycle", K_CONF, 0, 0, 32'h0);
      cycle();

      // forwarding
      drive(2'b01, 3, 32'h1, 0, 0, 0, 0, 1'b0, 0);
      cycle();
      drive(2'b10, 0, 0, 3, 32'hA5A5A5A5, 3, 3, 1'b0, 0);
      push_exp("x3_fwd_p0", K_RDATA, 1, 0, 32'hA5A5A5A5);
      push_exp("x3_fwd_p1", K_RDATA, 1, 1, 32'hA5A5A5A5);
      push_exp("x3_nofwd", K_RDATA, 0, 0, 32'h1);
      cycle();

      // scoreboard: issue, WAW stall, write-back clear
      drive(2'b00, 0, 0, 0, 0, 9, 0, 1'b1, 9);
      push_exp("x9_idle_busy", K_RBUSY, 0, 0, 32'h0);
      push_exp("x9_first_stall", K_STALL, 0, 0, 32'h0);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 9, 0, 1'b1, 9);
      push_exp("x9_busy", K_RBUSY, 0, 0, {31'b0, SB_EN});
      push_exp("x9_waw_stall", K_STALL, 0, 0, {31'b0, SB_EN});
      push_exp("x9_waw_stall_byp", K_STALL, 1, 0, {31'b0, SB_EN});
      cycle();
      drive(2'b01, 9, 32'h99, 0, 0, 9, 0, 1'b0, 0);
      push_exp("x9_busy_wb", K_RBUSY, 0, 0, {31'b0, SB_EN});
      push_exp("x9_busy_fwd", K_RBUSY, 1, 0, 32'h0);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 9, 0, 1'b0, 0);
      push_exp("x9_cleared", K_RBUSY, 0, 0, 32'h0);
      push_exp("x9_cleared_byp", K_RBUSY, 1, 0, 32'h0);
      cycle();

      // set beats clear; forwarding removes stall
      drive(2'b01, 4, 32'h44, 0, 0, 4, 0, 1'b1, 4);
      cycle();
      drive(2'b01, 4, 32'h45, 0, 0, 4, 0, 1'b1, 4);
      push_exp("x4_set_wins", K_RBUSY, 0, 0, {31'b0, SB_EN});
      push_exp("x4_stall", K_STALL, 0, 0, {31'b0, SB_EN});
      push_exp("x4_stall_fwd", K_STALL, 1, 0, 32'h0);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 4, 0, 1'b0, 0);
      push_exp("x4_busy_nofwd", K_RBUSY, 0, 0, 32'h0);
      push_exp("x4_busy_fwd", K_RBUSY, 1, 0, {31'b0, SB_EN});
      cycle();

      // asynchronous reset between edges
      drive(2'b11, 7, 32'h55, 7, 32'h66, 5, 7, 1'b1, 12);
      cycle();
      drive(2'b00, 0, 0, 0, 0, 5, 12, 1'b0, 0);
      #1;
      push_exp("pre_rst_conf", K_CONF, 0, 0, 32'h1);
      push_exp("pre_rst_x5", K_RDATA, 0, 0, 32'hDEADBEEF);
      push_exp("pre_rst_busy12", K_RBUSY, 0, 1, {31'b0, SB_EN});
      flush();
      rst = 1'b1;
      #1;
      model_clear();
      for (int d = 0; d < 2; d++) begin
         push_exp($sformatf("arst_x5_d%0d", d), K_RDATA, d, 0, 32'h0);
         push_exp($sformatf("arst_busy_d%0d", d), K_RBUSY, d, 1, 32'h0);
         push_exp($sformatf("arst_conf_d%0d", d), K_CONF, d, 0, 32'h0);
         push_exp($sformatf("arst_stall_d%0d", d), K_STALL, d, 0, 32'h0);
      end
      flush();
      cycle();

      // write presented as reset falls is honoured
      drive(2'b01, 6, 32'h66, 0, 0, 6, 0, 1'b0, 0);
      cycle();
      drive(2'b01, 6, 32'h67, 0, 0, 6, 0, 1'b0, 0);
      #2;
      rst = 1'b0;
      cycle();
      drive(2'b00, 0, 0, 0, 0, 6, 5, 1'b0, 0);
      push_exp("x6_after_rst", K_RDATA, 0, 0, 32'h67);
      push_exp("x5_after_rst", K_RDATA, 0, 1, 32'h0);
      cycle();

      // random traffic over a narrow address range to provoke collisions
      for (int i = 0; i < 48; i++) begin
         drive(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom,
               $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
